xdma_wr: RTL and testbench
==========================

XDMA_WR -- requirements
Module: xdma_wr

Interface
REQ-001 Parameter ADDR_W, 32, byte-address width of request and memory address.
REQ-002 Parameter LEN_W, 11, beat-count field width of a request.
REQ-003 xdma_clk  in  1  single clock; all state on rising edge.
REQ-004 xdma_rst_n  in  1  reset; asynchronous assert, active-low.
REQ-005 s0_xdfil2dma_req_data  in  43  stream-0 write request {len[42:32], addr[31:0]}.
REQ-006 s0_xdfil2dma_req_valid  in  1  stream-0 request valid.
REQ-007 s0_xdfil2dma_req_stall  out  1  stream-0 request backpressure.
REQ-008 s1_xdfil2dma_req_data / _valid / _stall  in/in/out  43/1/1  stream-1 request, same format.
REQ-009 xdfil2dma_wr_data  in  128  write-data beat.
REQ-010 xdfil2dma_wr_valid  in  1  write beat valid.
REQ-011 xdfil2dma_wr_stall  out  1  write beat backpressure.
REQ-012 dma_mem_wen / dma_mem_waddr / dma_mem_wdata  out  1/32/128  memory write port.
REQ-013 dma_mem_stall  in  1  memory backpressure.
REQ-014 dma2xdfil_done_valid  out  1  one-cycle completion pulse.
REQ-015 dma2xdfil_done_id  out  1  stream (0/1) of completed request.
REQ-016 xdma_intr  out  1  sticky misaligned-address flag.
REQ-017 xdma_intr_clr  in  1  clears xdma_intr.

Function
REQ-018 Every channel SHALL transfer exactly on cycles where valid=1 and stall=0.
REQ-019 FSM states SHALL be IDLE, DATA, DONE.
REQ-020 IDLE: s0/s1 req_stall SHALL be 0 only for the round-robin-granted valid stream; all others 1; in DATA/DONE both SHALL be 1.
REQ-021 Arbitration SHALL favour the stream not granted last; with one valid stream it is granted immediately; after reset stream 0 has priority.
REQ-022 On request accept, len and addr SHALL be registered; next state DATA if len!=0, DONE if len==0.
REQ-023 Misaligned addr (addr[3:0]!=0) SHALL be forced to addr & ~0xF and set xdma_intr the next cycle.
REQ-024 xdfil2dma_wr_stall SHALL equal (state!=DATA) | dma_mem_stall.
REQ-025 dma_mem_wen SHALL equal (state==DATA) & xdfil2dma_wr_valid; wdata passes combinationally; waddr = current address register.
REQ-026 Each accepted beat SHALL add 16 to the address (mod 2^32 wrap) and decrement remaining count; the last beat moves to DONE.
REQ-027 DONE: dma2xdfil_done_valid=1 for exactly one cycle with done_id = granted stream; then IDLE and arbitration pointer updates.
REQ-028 Request-to-first-write latency SHALL be 1 cycle (accept in cycle N, earliest wen in N+1); back-to-back requests have a 2-cycle gap (DONE, IDLE).
REQ-029 xdma_intr_clr coincident with a new misalign event: set SHALL win.
REQ-030 len field max 2047 beats; no length check beyond zero.

Reset
REQ-031 Asserting xdma_rst_n=0 at any time, including mid-burst, SHALL force IDLE, clear counters, address, arbitration pointer (stream 0 first) and xdma_intr; no done pulse for the aborted request.
REQ-032 During reset: req_stall=1, wr_stall=1, dma_mem_wen=0, done_valid=0, waddr=0, done_id=0.

Structure
REQ-033 Package xdma_pkg SHALL hold the request struct typedef {len, addr}, state enum, and BEAT_BYTES=16 constant.
REQ-034 Round-robin grant SHALL be a sub-module xdma_rr_arb (2 requesters, grant, update-on-accept).

Verification
REQ-035 s0 req {len=4, addr=0x1000}, 4 beats, no stall -> wen at 0x1000/1010/1020/1030, one done pulse id=0.
REQ-036 s0 and s1 valid together twice -> grants order s0, s1, s0, s1; each non-granted req_stall=1.
REQ-037 dma_mem_stall toggled every other cycle, len=3 -> wr_stall mirrors it; exactly 3 writes, addresses unchanged while stalled.
REQ-038 len=0 -> no wen, done pulse 1 cycle after accept; addr=0x1004 -> writes from 0x1000, xdma_intr=1 until xdma_intr_clr.
REQ-039 addr=0xFFFFFFF0, len=2 -> writes at 0xFFFFFFF0 then 0x00000000.
REQ-040 Reset asserted after 2 of 5 beats -> outputs at reset values, no done; fresh request afterwards completes normally with stream 0 priority.

Source files
------------

// File: rtl/xdma_pkg.sv
// Shared types and constants for the XDMA write engine.
// The request struct mirrors the 43-bit request bus layout {len, addr}.
package xdma_pkg;

    localparam int XDMA_ADDR_W = 32;
    localparam int XDMA_LEN_W  = 11;
    localparam int BEAT_BYTES  = 16;

    typedef struct packed {
        logic [XDMA_LEN_W-1:0]  len;
        logic [XDMA_ADDR_W-1:0] addr;
    } xdma_req_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_DONE = 2'd2
    } xdma_state_e;

endpackage

// File: rtl/xdma_wr_if.sv
// Request, write-data, memory and completion signals of the XDMA write engine.
// Handshake rule on every channel: a transfer happens on a cycle with valid=1 and stall=0.
interface xdma_wr_if #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 11
);
    logic [LEN_W+ADDR_W-1:0] s0_xdfil2dma_req_data;
    logic                    s0_xdfil2dma_req_valid;
    logic                    s0_xdfil2dma_req_stall;
    logic [LEN_W+ADDR_W-1:0] s1_xdfil2dma_req_data;
    logic                    s1_xdfil2dma_req_valid;
    logic                    s1_xdfil2dma_req_stall;
    logic [127:0]            xdfil2dma_wr_data;
    logic                    xdfil2dma_wr_valid;
    logic                    xdfil2dma_wr_stall;
    logic                    dma_mem_wen;
    logic [ADDR_W-1:0]       dma_mem_waddr;
    logic [127:0]            dma_mem_wdata;
    logic                    dma_mem_stall;
    logic                    dma2xdfil_done_valid;
    logic                    dma2xdfil_done_id;
    logic                    xdma_intr;
    logic                    xdma_intr_clr;

    modport slave (
        input  s0_xdfil2dma_req_data, s0_xdfil2dma_req_valid,
        input  s1_xdfil2dma_req_data, s1_xdfil2dma_req_valid,
        input  xdfil2dma_wr_data, xdfil2dma_wr_valid, dma_mem_stall, xdma_intr_clr,
        output s0_xdfil2dma_req_stall, s1_xdfil2dma_req_stall, xdfil2dma_wr_stall,
        output dma_mem_wen, dma_mem_waddr, dma_mem_wdata,
        output dma2xdfil_done_valid, dma2xdfil_done_id, xdma_intr
    );

    modport master (
        output s0_xdfil2dma_req_data, s0_xdfil2dma_req_valid,
        output s1_xdfil2dma_req_data, s1_xdfil2dma_req_valid,
        output xdfil2dma_wr_data, xdfil2dma_wr_valid, dma_mem_stall, xdma_intr_clr,
        input  s0_xdfil2dma_req_stall, s1_xdfil2dma_req_stall, xdfil2dma_wr_stall,
        input  dma_mem_wen, dma_mem_waddr, dma_mem_wdata,
        input  dma2xdfil_done_valid, dma2xdfil_done_id, xdma_intr
    );
endinterface

// File: rtl/xdma_rr_arb.sv
// Two-requester round-robin arbiter; the pointer moves only when a grant is accepted.
// Out of reset stream 0 wins a tie.
module xdma_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);
    // Stream granted most recently; starts at 1 so stream 0 is favoured first.
    logic last_id;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_id ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_id <= 1'b1;
        end else if (update) begin
            last_id <= grant[1];
        end
    end
endmodule

// File: rtl/xdma_wr.sv
// Two-stream DMA write engine: arbitrates a burst request, streams its 16-byte
// beats to the memory port, then pulses a completion tagged with the stream id.
module xdma_wr
    import xdma_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 11
) (
    input  logic        xdma_clk,
    input  logic        xdma_rst_n,
    xdma_wr_if.slave    bus,
    output xdma_state_e state_dbg
);
    xdma_state_e       state, state_nxt;
    logic [LEN_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              id_q;
    logic              intr_q;
    logic [1:0]        req_vec;
    logic [1:0]        grant;
    logic              accept;
    logic              beat;
    logic              misalign;
    xdma_req_t         req_sel;

    // Requests are only visible to the arbiter while idle and out of reset,
    // so both request stalls read 1 during reset and in DATA/DONE.
    assign req_vec = {bus.s1_xdfil2dma_req_valid, bus.s0_xdfil2dma_req_valid}
                   & {2{(state == ST_IDLE) & xdma_rst_n}};

    xdma_rr_arb u_arb (
        .clk    (xdma_clk),
        .rst_n  (xdma_rst_n),
        .req    (req_vec),
        .update (accept),
        .grant  (grant)
    );

    assign accept   = |grant;
    assign req_sel  = grant[1] ? xdma_req_t'(bus.s1_xdfil2dma_req_data)
                               : xdma_req_t'(bus.s0_xdfil2dma_req_data);
    assign misalign = accept & (|req_sel.addr[3:0]);
    assign beat     = (state == ST_DATA) & bus.xdfil2dma_wr_valid & ~bus.dma_mem_stall;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = (req_sel.len == '0) ? ST_DONE : ST_DATA;
            ST_DATA: if (beat && cnt == LEN_W'(1)) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge xdma_clk or negedge xdma_rst_n) begin
        if (!xdma_rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            addr_q <= '0;
            id_q   <= 1'b0;
            intr_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q <= {req_sel.addr[ADDR_W-1:4], 4'b0000};
                cnt    <= req_sel.len;
                id_q   <= grant[1];
            end else if (beat) begin
                addr_q <= addr_q + ADDR_W'(BEAT_BYTES);
                cnt    <= cnt - LEN_W'(1);
            end
            // A new misalign event outranks a coincident clear.
            if (misalign) begin
                intr_q <= 1'b1;
            end else if (bus.xdma_intr_clr) begin
                intr_q <= 1'b0;
            end
        end
    end

    assign bus.s0_xdfil2dma_req_stall = ~grant[0];
    assign bus.s1_xdfil2dma_req_stall = ~grant[1];
    assign bus.xdfil2dma_wr_stall     = (state != ST_DATA) | bus.dma_mem_stall;
    assign bus.dma_mem_wen            = (state == ST_DATA) & bus.xdfil2dma_wr_valid;
    assign bus.dma_mem_waddr          = addr_q;
    assign bus.dma_mem_wdata          = bus.xdfil2dma_wr_data;
    assign bus.dma2xdfil_done_valid   = (state == ST_DONE);
    assign bus.dma2xdfil_done_id      = id_q;
    assign bus.xdma_intr              = intr_q;
    assign state_dbg                  = state;
endmodule

// File: tb/tb_xdma_wr.sv
// Directed bench for xdma_wr: bursts, arbitration, backpressure, zero length,
// misalignment, address wrap and mid-burst reset.
module tb_xdma_wr;
    import xdma_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    xdma_state_e state_dbg;
    int          vec_cnt = 0;
    int          miss_cnt = 0;
    logic [159:0] exp_q[$];
    logic [159:0] act_q[$];

    xdma_wr_if bus ();

    xdma_wr dut (
        .xdma_clk   (clk),
        .xdma_rst_n (rst_n),
        .bus        (bus),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    function automatic logic [127:0] beat_data(input logic [31:0] a);
        return {a, ~a, a ^ 32'h5A5A_5A5A, 32'hC0DE_0000 ^ {a[15:0], a[31:16]}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input bit sid, input logic [10:0] len, input logic [31:0] addr);
        int   cyc = 0;
        logic stall;
        if (sid) begin
            bus.s1_xdfil2dma_req_data = {len, addr};
            bus.s1_xdfil2dma_req_valid = 1'b1;
        end else begin
            bus.s0_xdfil2dma_req_data = {len, addr};
            bus.s0_xdfil2dma_req_valid = 1'b1;
        end
        do begin
            @(negedge clk);
            stall = sid ? bus.s1_xdfil2dma_req_stall : bus.s0_xdfil2dma_req_stall;
            cyc++;
        end while (stall && cyc < 50);
        if (stall) begin
            vec_cnt++; miss_cnt++;
            $display("FAIL req_accept_timeout stream=%0d stall=%b required=0", sid, stall);
        end
        @(posedge clk);
        #1;
        if (sid) bus.s1_xdfil2dma_req_valid = 1'b0;
        else     bus.s0_xdfil2dma_req_valid = 1'b0;
    endtask

    // Presents n beats; a beat is taken by the engine whenever the memory is not stalling.
    task automatic drive_beats(input int n, input bit toggle, input logic [31:0] base);
        int          sent = 0;
        int          cyc = 0;
        logic [31:0] a = base;
        while (sent < n && cyc < 100) begin
            bus.xdfil2dma_wr_valid = 1'b1;
            bus.xdfil2dma_wr_data  = beat_data(a);
            bus.dma_mem_stall      = toggle && (cyc % 2 == 0);
            @(negedge clk);
            vec_cnt++;
            if (bus.xdfil2dma_wr_stall !== bus.dma_mem_stall) begin
                miss_cnt++;
                $display("FAIL wr_stall got=%b exp=%b", bus.xdfil2dma_wr_stall, bus.dma_mem_stall);
            end
            vec_cnt++;
            if (bus.dma_mem_waddr !== a) begin
                miss_cnt++;
                $display("FAIL waddr_track got=%h exp=%h", bus.dma_mem_waddr, a);
            end
            if (bus.dma_mem_wen && !bus.dma_mem_stall)
                act_q.push_back({bus.dma_mem_waddr, bus.dma_mem_wdata});
            @(posedge clk);
            #1;
            if (!bus.dma_mem_stall) begin
                sent++;
                a = a + 32'd16;
            end
            cyc++;
        end
        if (sent < n) begin
            vec_cnt++; miss_cnt++;
            $display("FAIL beat_timeout sent=%0d required=%0d", sent, n);
        end
        bus.xdfil2dma_wr_valid = 1'b0;
        bus.dma_mem_stall      = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.s0_xdfil2dma_req_data  = {11'd4, 32'h0000_1000};
        bus.s0_xdfil2dma_req_valid = 1'b1;
        bus.s1_xdfil2dma_req_data  = {11'd4, 32'h0000_2000};
        bus.s1_xdfil2dma_req_valid = 1'b1;
        bus.xdfil2dma_wr_valid = 1'b1;
        bus.xdfil2dma_wr_data  = '0;
        bus.dma_mem_stall      = 1'b0;
        bus.xdma_intr_clr      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vec_cnt++; if (bus.s0_xdfil2dma_req_stall !== 1'b1) begin miss_cnt++; $display("FAIL rst_s0_stall got=%b exp=1", bus.s0_xdfil2dma_req_stall); end
        vec_cnt++; if (bus.s1_xdfil2dma_req_stall !== 1'b1) begin miss_cnt++; $display("FAIL rst_s1_stall got=%b exp=1", bus.s1_xdfil2dma_req_stall); end
        vec_cnt++; if (bus.xdfil2dma_wr_stall !== 1'b1) begin miss_cnt++; $display("FAIL rst_wr_stall got=%b exp=1", bus.xdfil2dma_wr_stall); end
        vec_cnt++; if (bus.dma_mem_wen !== 1'b0) begin miss_cnt++; $display("FAIL rst_wen got=%b exp=0", bus.dma_mem_wen); end
        vec_cnt++; if (bus.dma2xdfil_done_valid !== 1'b0) begin miss_cnt++; $display("FAIL rst_done got=%b exp=0", bus.dma2xdfil_done_valid); end
        vec_cnt++; if (bus.dma_mem_waddr !== 32'h0) begin miss_cnt++; $display("FAIL rst_waddr got=%h exp=0", bus.dma_mem_waddr); end
        vec_cnt++; if (bus.dma2xdfil_done_id !== 1'b0) begin miss_cnt++; $display("FAIL rst_done_id got=%b exp=0", bus.dma2xdfil_done_id); end
        vec_cnt++; if (bus.xdma_intr !== 1'b0) begin miss_cnt++; $display("FAIL rst_intr got=%b exp=0", bus.xdma_intr); end
        vec_cnt++; if (state_dbg !== ST_IDLE) begin miss_cnt++; $display("FAIL rst_state got=%0d exp=%0d", state_dbg, ST_IDLE); end
        bus.s0_xdfil2dma_req_valid = 1'b0;
        bus.s1_xdfil2dma_req_valid = 1'b0;
        bus.xdfil2dma_wr_valid     = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [159:0] e, a;
        for (int i = 0; i < 4; i++) exp_q.push_back({32'h1000 + 32'(i * 16), beat_data(32'h1000 + 32'(i * 16))});
        send_req(1'b0, 11'd4, 32'h0000_1000);
        drive_beats(4, 1'b0, 32'h0000_1000);
        @(negedge clk);
        vec_cnt++; if (bus.dma2xdfil_done_valid !== 1'b1) begin miss_cnt++; $display("FAIL basic_done got=%b exp=1", bus.dma2xdfil_done_valid); end
        vec_cnt++; if (bus.dma2xdfil_done_id !== 1'b0) begin miss_cnt++; $display("FAIL basic_done_id got=%b exp=0", bus.dma2xdfil_done_id); end
        tick();
        @(negedge clk);
        vec_cnt++; if (bus.dma2xdfil_done_valid !== 1'b0) begin miss_cnt++; $display("FAIL basic_done_width got=%b exp=0", bus.dma2xdfil_done_valid); end
        tick();
        vec_cnt++; if (act_q.size() !== exp_q.size()) begin miss_cnt++; $display("FAIL basic_wr_count got=%0d exp=%0d", act_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); vec_cnt++;
            if (a !== e) begin miss_cnt++; $display("FAIL basic_wr got=%h exp=%h", a, e); end
        end
        exp_q.delete(); act_q.delete();
    endtask

    task automatic test_stall();
        logic [159:0] e, a;
        for (int i = 0; i < 3; i++) exp_q.push_back({32'h2000 + 32'(i * 16), beat_data(32'h2000 + 32'(i * 16))});
        send_req(1'b1, 11'd3, 32'h0000_2000);
        drive_beats(3, 1'b1, 32'h0000_2000);
        @(negedge clk);
        vec_cnt++; if (bus.dma2xdfil_done_valid !== 1'b1) begin miss_cnt++; $display("FAIL stall_done got=%b exp=1", bus.dma2xdfil_done_valid); end
        vec_cnt++; if (bus.dma2xdfil_done_id !== 1'b1) begin miss_cnt++; $display("FAIL stall_done_id got=%b exp=1", bus.dma2xdfil_done_id); end
        tick();
        vec_cnt++; if (act_q.size() !== exp_q.size()) begin miss_cnt++; $display("FAIL stall_wr_count got=%0d exp=%0d", act_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); vec_cnt++;
            if (a !== e) begin miss_cnt++; $display("FAIL stall_wr got=%h exp=%h", a, e); end
        end
        exp_q.delete(); act_q.delete();
    endtask

    // Stream 1 went last in the previous test, so the first tie goes to stream 0.
    task automatic test_arb();
        logic [159:0] e, a;
        logic [31:0]  a0, a1, ag;
        bit           g;
        bus.s0_xdfil2dma_req_valid = 1'b1;
        bus.s1_xdfil2dma_req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            g  = k[0];
            a0 = 32'h3000 + 32'(k * 256);
            a1 = 32'h4000 + 32'(k * 256);
            bus.s0_xdfil2dma_req_data = {11'd1, a0};
            bus.s1_xdfil2dma_req_data = {11'd1, a1};
            ag = g ? a1 : a0;
            exp_q.push_back({ag, beat_data(ag)});
            @(negedge clk);
            vec_cnt++; if (bus.s0_xdfil2dma_req_stall !== g) begin miss_cnt++; $display("FAIL arb_s0_stall k=%0d got=%b exp=%b", k, bus.s0_xdfil2dma_req_stall, g); end
            vec_cnt++; if (bus.s1_xdfil2dma_req_stall !== !g) begin miss_cnt++; $display("FAIL arb_s1_stall k=%0d got=%b exp=%b", k, bus.s1_xdfil2dma_req_stall, !g); end
            @(posedge clk);
            #1;
            if (g) bus.s1_xdfil2dma_req_valid = 1'b0;
            else   bus.s0_xdfil2dma_req_valid = 1'b0;
            if (k == 3) begin
                bus.s0_xdfil2dma_req_valid = 1'b0;
                bus.s1_xdfil2dma_req_valid = 1'b0;
            end
            drive_beats(1, 1'b0, ag);
            @(negedge clk);
            vec_cnt++; if (bus.dma2xdfil_done_id !== g) begin miss_cnt++; $display("FAIL arb_done_id k=%0d got=%b exp=%b", k, bus.dma2xdfil_done_id, g); end
            vec_cnt++; if ({bus.s1_xdfil2dma_req_stall, bus.s0_xdfil2dma_req_stall} !== 2'b11) begin miss_cnt++; $display("FAIL arb_done_stalls k=%0d got=%b%b exp=11", k, bus.s1_xdfil2dma_req_stall, bus.s0_xdfil2dma_req_stall); end
            tick();
            if (k < 3) begin
                if (g) bus.s1_xdfil2dma_req_valid = 1'b1;
                else   bus.s0_xdfil2dma_req_valid = 1'b1;
            end
        end
        vec_cnt++; if (act_q.size() !== exp_q.size()) begin miss_cnt++; $display("FAIL arb_wr_count got=%0d exp=%0d", act_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); vec_cnt++;
            if (a !== e) begin miss_cnt++; $display("FAIL arb_wr got=%h exp=%h", a, e); end
        end
        exp_q.delete(); act_q.delete();
    endtask

    task automatic test_zero_misalign();
        logic [159:0] e, a;
        send_req(1'b0, 11'd0, 32'h0000_4000);
        @(negedge clk);
        vec_cnt++; if (bus.dma2xdfil_done_valid !== 1'b1) begin miss_cnt++; $display("FAIL zero_done got=%b exp=1", bus.dma2xdfil_done_valid); end
        vec_cnt++; if (bus.dma_mem_wen !== 1'b0) begin miss_cnt++; $display("FAIL zero_wen got=%b exp=0", bus.dma_mem_wen); end
        vec_cnt++; if (bus.xdma_intr !== 1'b0) begin miss_cnt++; $display("FAIL zero_intr got=%b exp=0", bus.xdma_intr); end
        tick();
        @(negedge clk);
        vec_cnt++; if (bus.dma2xdfil_done_valid !== 1'b0) begin miss_cnt++; $display("FAIL zero_done_width got=%b exp=0", bus.dma2xdfil_done_valid); end
        tick();
        exp_q.push_back({32'h1000, beat_data(32'h1000)});
        exp_q.push_back({32'h1010, beat_data(32'h1010)});
        send_req(1'b0, 11'd2, 32'h0000_1004);
        drive_beats(2, 1'b0, 32'h0000_1000);
        @(negedge clk);
        vec_cnt++; if (bus.xdma_intr !== 1'b1) begin miss_cnt++; $display("FAIL mis_intr got=%b exp=1", bus.xdma_intr); end
        tick();
        @(negedge clk);
        vec_cnt++; if (bus.xdma_intr !== 1'b1) begin miss_cnt++; $display("FAIL mis_intr_sticky got=%b exp=1", bus.xdma_intr); end
        tick();
        bus.xdma_intr_clr = 1'b1;
        send_req(1'b0, 11'd0, 32'h0000_5008);
        @(negedge clk);
        vec_cnt++; if (bus.xdma_intr !== 1'b1) begin miss_cnt++; $display("FAIL intr_set_wins got=%b exp=1", bus.xdma_intr); end
        tick();
        @(negedge clk);
        vec_cnt++; if (bus.xdma_intr !== 1'b0) begin miss_cnt++; $display("FAIL intr_clear got=%b exp=0", bus.xdma_intr); end
        tick();
        bus.xdma_intr_clr = 1'b0;
        vec_cnt++; if (act_q.size() !== exp_q.size()) begin miss_cnt++; $display("FAIL mis_wr_count got=%0d exp=%0d", act_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); vec_cnt++;
            if (a !== e) begin miss_cnt++; $display("FAIL mis_wr got=%h exp=%h", a, e); end
        end
        exp_q.delete(); act_q.delete();
    endtask

    task automatic test_wrap();
        logic [159:0] e, a;
        exp_q.push_back({32'hFFFF_FFF0, beat_data(32'hFFFF_FFF0)});
        exp_q.push_back({32'h0000_0000, beat_data(32'h0000_0000)});
        send_req(1'b0, 11'd2, 32'hFFFF_FFF0);
        drive_beats(2, 1'b0, 32'hFFFF_FFF0);
        @(negedge clk);
        vec_cnt++; if (bus.dma2xdfil_done_valid !== 1'b1) begin miss_cnt++; $display("FAIL wrap_done got=%b exp=1", bus.dma2xdfil_done_valid); end
        tick();
        vec_cnt++; if (act_q.size() !== exp_q.size()) begin miss_cnt++; $display("FAIL wrap_wr_count got=%0d exp=%0d", act_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); vec_cnt++;
            if (a !== e) begin miss_cnt++; $display("FAIL wrap_wr got=%h exp=%h", a, e); end
        end
        exp_q.delete(); act_q.delete();
    endtask

    // Last grant before the reset is stream 0, so a tie right after reset proves the pointer was cleared.
    task automatic test_reset_mid();
        logic [159:0] e, a;
        exp_q.push_back({32'h6000, beat_data(32'h6000)});
        exp_q.push_back({32'h6010, beat_data(32'h6010)});
        send_req(1'b0, 11'd5, 32'h0000_6008);
        drive_beats(2, 1'b0, 32'h0000_6000);
        bus.xdfil2dma_wr_valid     = 1'b1;
        bus.s0_xdfil2dma_req_data  = {11'd1, 32'h0000_7000};
        bus.s1_xdfil2dma_req_data  = {11'd1, 32'h0000_8000};
        bus.s0_xdfil2dma_req_valid = 1'b1;
        bus.s1_xdfil2dma_req_valid = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        vec_cnt++; if (bus.dma_mem_wen !== 1'b0) begin miss_cnt++; $display("FAIL mid_rst_wen got=%b exp=0", bus.dma_mem_wen); end
        vec_cnt++; if (bus.xdfil2dma_wr_stall !== 1'b1) begin miss_cnt++; $display("FAIL mid_rst_wr_stall got=%b exp=1", bus.xdfil2dma_wr_stall); end
        vec_cnt++; if (bus.dma_mem_waddr !== 32'h0) begin miss_cnt++; $display("FAIL mid_rst_waddr got=%h exp=0", bus.dma_mem_waddr); end
        vec_cnt++; if (bus.xdma_intr !== 1'b0) begin miss_cnt++; $display("FAIL mid_rst_intr got=%b exp=0", bus.xdma_intr); end
        vec_cnt++; if ({bus.s1_xdfil2dma_req_stall, bus.s0_xdfil2dma_req_stall} !== 2'b11) begin miss_cnt++; $display("FAIL mid_rst_req_stall got=%b%b exp=11", bus.s1_xdfil2dma_req_stall, bus.s0_xdfil2dma_req_stall); end
        vec_cnt++; if (state_dbg !== ST_IDLE) begin miss_cnt++; $display("FAIL mid_rst_state got=%0d exp=%0d", state_dbg, ST_IDLE); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vec_cnt++; if (bus.dma2xdfil_done_valid !== 1'b0) begin miss_cnt++; $display("FAIL mid_rst_no_done got=%b exp=0", bus.dma2xdfil_done_valid); end
        end
        bus.xdfil2dma_wr_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        vec_cnt++; if (bus.s0_xdfil2dma_req_stall !== 1'b0) begin miss_cnt++; $display("FAIL post_rst_s0_stall got=%b exp=0", bus.s0_xdfil2dma_req_stall); end
        vec_cnt++; if (bus.s1_xdfil2dma_req_stall !== 1'b1) begin miss_cnt++; $display("FAIL post_rst_s1_stall got=%b exp=1", bus.s1_xdfil2dma_req_stall); end
        @(posedge clk);
        #1;
        bus.s0_xdfil2dma_req_valid = 1'b0;
        bus.s1_xdfil2dma_req_valid = 1'b0;
        exp_q.push_back({32'h7000, beat_data(32'h7000)});
        drive_beats(1, 1'b0, 32'h0000_7000);
        @(negedge clk);
        vec_cnt++; if (bus.dma2xdfil_done_valid !== 1'b1) begin miss_cnt++; $display("FAIL post_rst_done got=%b exp=1", bus.dma2xdfil_done_valid); end
        vec_cnt++; if (bus.dma2xdfil_done_id !== 1'b0) begin miss_cnt++; $display("FAIL post_rst_done_id got=%b exp=0", bus.dma2xdfil_done_id); end
        tick();
        vec_cnt++; if (act_q.size() !== exp_q.size()) begin miss_cnt++; $display("FAIL mid_wr_count got=%0d exp=%0d", act_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); vec_cnt++;
            if (a !== e) begin miss_cnt++; $display("FAIL mid_wr got=%h exp=%h", a, e); end
        end
        exp_q.delete(); act_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_arb();
        test_zero_misalign();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
